fetch_stage: RTL

//  IF stage plus IF/ID pipeline register for the 5-stage MIPS pipeline_cpu.

---
 rtl/fetch_stage.sv | 74 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: PC, instruction-memory address, next-PC select.
// Latency: instruction at pc reaches ID_* one edge later; no delay slot.
// Stall holds PC and IF/ID; branch/jump/flush insert a NOP bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_AW    = 10,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    output logic [IM_AW-1:0] imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ID_pc,
    output logic [31:0]      ID_instruction,
    output logic             ID_valid,
    output logic [31:0]      fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_off;
    logic        jump_eff;
    logic        bubble;
    logic        load;
    logic        unused_bits;

    // IM is indexed relative to RESET_PC; out-of-range PCs alias by truncation
    assign pc_off      = pc - RESET_PC;
    assign imem_addr   = pc_off[IM_AW+1:2];
    assign unused_bits = ^{pc_off[31:IM_AW+2], pc_off[1:0], br_target[1:0], jump_target[1:0]};

    always_comb begin
        jump_eff = jump & ~stall;
        bubble   = br_taken | flush | jump_eff;
        load     = ~bubble & ~stall;
        pc_next  = pc + 32'd4;
        if (br_taken) begin
            pc_next = {br_target[31:2], 2'b00};
        end else if (jump_eff) begin
            pc_next = {jump_target[31:2], 2'b00};
        end else if (stall) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc             <= RESET_PC;
            ID_pc          <= 32'd0;
            ID_instruction <= NOP;
            ID_valid       <= 1'b0;
            fetch_count    <= 32'd0;
        end else begin
            pc <= pc_next;
            if (bubble) begin
                ID_instruction <= NOP;
                ID_valid       <= 1'b0;
                ID_pc          <= pc;
            end else if (load) begin
                ID_instruction <= imem_rdata;
                ID_valid       <= 1'b1;
                ID_pc          <= pc;
                fetch_count    <= fetch_count + 32'd1;
            end
        end
    end

endmodule
